// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle between the hazard/branch/memory sources and the stall sequencer.
// Latency: none, wires only.
// Backpressure: mem_req/mem_ready is the only handshake; everything else is a level request.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    // Requests into the sequencer
    logic             data_hazard;
    logic             jump_id;
    logic             branch_ex;
    logic             mem_req;
    logic             mem_ready;
    // Per-stage controls out of the sequencer
    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [1:0]       stall_state;
    logic             hazard_timeout;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;
    logic [CNT_W-1:0] perf_memwait_cnt;

    // Request side: hazard unit, branch/jump logic, data memory
    modport master (
        output data_hazard, jump_id, branch_ex, mem_req, mem_ready,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        input  if_id_flush, id_ex_flush, stall_state, hazard_timeout,
        input  perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt
    );

    // Sequencer side
    modport slave (
        input  data_hazard, jump_id, branch_ex, mem_req, mem_ready,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        output if_id_flush, id_ex_flush, stall_state, hazard_timeout,
        output perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; optional perf counters behind PERF_CNT_EN.
// Latency: zero cycles, enables/flushes are Mealy outputs; state and counters update on the edge.
// Backpressure: an unfinished data-memory access freezes every stage until mem_ready.
module pipeline_stall_ctrl #(
    parameter int HAZ_LIMIT = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_stall_ctrl_if.slave bus
);

    localparam int HCW = $clog2(HAZ_LIMIT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        HAZ      = 2'b01,
        MEM_WAIT = 2'b10
    } stallState_e;

    stallState_e    curState;
    stallState_e    nextState;
    logic [HCW-1:0] hazCnt;
    logic           hazTimeout;

    // Which rule won this cycle; drives the counters
    logic memBlocked;
    logic doFreeze;
    logic doBranch;
    logic doStall;
    logic doJump;

    logic pcWe;
    logic ifIdWe;
    logic idExWe;
    logic exMemWe;
    logic memWbWe;
    logic ifIdFlush;
    logic idExFlush;

    // Priority decode: freeze > branch > hazard > jump > advance
    always_comb begin
        pcWe       = 1'b0;
        ifIdWe     = 1'b0;
        idExWe     = 1'b0;
        exMemWe    = 1'b0;
        memWbWe    = 1'b0;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        nextState  = RUN;
        memBlocked = 1'b0;
        doFreeze   = 1'b0;
        doBranch   = 1'b0;
        doStall    = 1'b0;
        doJump     = 1'b0;

        if (reset) begin
            // Hold the pipe and fill the front registers with bubbles
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else begin
            // In MEM_WAIT only mem_ready matters; mem_req is held by the frozen MEM stage
            if (curState == MEM_WAIT) begin
                memBlocked = !bus.mem_ready;
            end else begin
                memBlocked = bus.mem_req && !bus.mem_ready;
            end

            if (memBlocked) begin
                doFreeze  = 1'b1;
                nextState = MEM_WAIT;
            end else if (bus.branch_ex) begin
                // ID instruction is on the wrong path, so its hazard/jump is moot
                doBranch  = 1'b1;
                pcWe      = 1'b1;
                ifIdWe    = 1'b1;
                idExWe    = 1'b1;
                exMemWe   = 1'b1;
                memWbWe   = 1'b1;
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
                nextState = RUN;
            end else if (bus.data_hazard) begin
                // Hold PC and IF/ID, push a bubble into EX, let the back end drain
                doStall   = 1'b1;
                idExWe    = 1'b1;
                idExFlush = 1'b1;
                exMemWe   = 1'b1;
                memWbWe   = 1'b1;
                nextState = HAZ;
            end else if (bus.jump_id) begin
                // Fetched instruction after the jump is dead
                doJump    = 1'b1;
                pcWe      = 1'b1;
                ifIdWe    = 1'b1;
                idExWe    = 1'b1;
                exMemWe   = 1'b1;
                memWbWe   = 1'b1;
                ifIdFlush = 1'b1;
                nextState = RUN;
            end else begin
                pcWe      = 1'b1;
                ifIdWe    = 1'b1;
                idExWe    = 1'b1;
                exMemWe   = 1'b1;
                memWbWe   = 1'b1;
                nextState = RUN;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            curState <= RUN;
        end else begin
            curState <= nextState;
        end
    end

    // Consecutive-stall counter: counts rule-3 cycles, any other outcome clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            hazCnt <= '0;
        end else if (doStall) begin
            if (hazCnt != HCW'(HAZ_LIMIT)) begin
                hazCnt <= hazCnt + HCW'(1);
            end
        end else begin
            hazCnt <= '0;
        end
    end

    // Sticky watchdog: a hazard still pending after HAZ_LIMIT stalls in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            hazTimeout <= 1'b0;
        end else if (curState == HAZ && bus.data_hazard && hazCnt == HCW'(HAZ_LIMIT)) begin
            hazTimeout <= 1'b1;
        end
    end

    assign bus.pc_we          = pcWe;
    assign bus.if_id_we       = ifIdWe;
    assign bus.id_ex_we       = idExWe;
    assign bus.ex_mem_we      = exMemWe;
    assign bus.mem_wb_we      = memWbWe;
    assign bus.if_id_flush    = ifIdFlush;
    assign bus.id_ex_flush    = idExFlush;
    assign bus.stall_state    = curState;
    assign bus.hazard_timeout = hazTimeout;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
    logic [CNT_W-1:0] memWaitCnt;

    // Saturating event counters, one increment per qualifying cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt   <= '0;
            flushCnt   <= '0;
            memWaitCnt <= '0;
        end else begin
            if (doStall && stallCnt != '1) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if ((doBranch || doJump) && flushCnt != '1) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
            if (doFreeze && memWaitCnt != '1) begin
                memWaitCnt <= memWaitCnt + CNT_W'(1);
            end
        end
    end

    assign bus.perf_stall_cnt   = stallCnt;
    assign bus.perf_flush_cnt   = flushCnt;
    assign bus.perf_memwait_cnt = memWaitCnt;
`else
    assign bus.perf_stall_cnt   = {CNT_W{1'b0}};
    assign bus.perf_flush_cnt   = {CNT_W{1'b0}};
    assign bus.perf_memwait_cnt = {CNT_W{1'b0}};
`endif

    // A flushed register must also be written, otherwise the bubble never lands
    assert property (@(posedge clk) disable iff (reset) bus.id_ex_flush |-> bus.id_ex_we);
    assert property (@(posedge clk) disable iff (reset) bus.if_id_flush |-> bus.if_id_we);

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed test-plan sequences then randomized traffic.
// Expected responses come from a rule-level model and are queued; a monitor pops one per cycle.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_pipeline_stall_ctrl;

    localparam int HAZ_LIMIT = 3;
    localparam int CNT_W     = 32;

    logic clk;
    logic reset;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(
        .HAZ_LIMIT(HAZ_LIMIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       we;     // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [1:0]       flush;  // {if_id, id_ex}
        logic [1:0]       state;
        logic             tout;
        logic [CNT_W-1:0] pStall;
        logic [CNT_W-1:0] pFlush;
        logic [CNT_W-1:0] pMem;
        int               cyc;
    } expect_t;

    expect_t sbQ[$];
    int      nCmp = 0;
    int      nBad = 0;
    int      cycNo = 0;

    // Reference model state, in spec terms
    int      mMode;       // 0 RUN, 1 HAZ, 2 MEM_WAIT
    int      mRun;        // consecutive stall cycles, capped at HAZ_LIMIT
    bit      mTout;
    longint  mStall, mFlushN, mMemN;

    localparam longint PMAX = (64'd1 << CNT_W) - 64'd1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp, input int c);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, c, got, exp);
        end
    endtask

    // One clock cycle of stimulus: drive, predict, queue, advance the model
    task automatic cyc(input bit r, input bit dh, input bit j, input bit b, input bit mq, input bit mr);
        expect_t e;
        string   act;
        bit      blocked;
        @(posedge clk);
        #1;
        reset           = r;
        bus.data_hazard = dh;
        bus.jump_id     = j;
        bus.branch_ex   = b;
        bus.mem_req     = mq;
        bus.mem_ready   = mr;
        cycNo++;

        // Registered outputs show the model's state before this cycle's edge
        e.state  = 2'(mMode == 2 ? 2 : mMode);
        e.tout   = mTout;
`ifdef PERF_CNT_EN
        e.pStall = CNT_W'(mStall);
        e.pFlush = CNT_W'(mFlushN);
        e.pMem   = CNT_W'(mMemN);
`else
        e.pStall = '0;
        e.pFlush = '0;
        e.pMem   = '0;
`endif
        e.cyc = cycNo;

        if (r) begin
            act = "reset";
        end else begin
            blocked = (mMode == 2) ? !mr : (mq && !mr);
            if (blocked)   act = "freeze";
            else if (b)    act = "branch";
            else if (dh)   act = "stall";
            else if (j)    act = "jump";
            else           act = "advance";
        end

        case (act)
            "reset":   begin e.we = 5'b00000; e.flush = 2'b11; end
            "freeze":  begin e.we = 5'b00000; e.flush = 2'b00; end
            "branch":  begin e.we = 5'b11111; e.flush = 2'b11; end
            "stall":   begin e.we = 5'b00111; e.flush = 2'b01; end
            "jump":    begin e.we = 5'b11111; e.flush = 2'b10; end
            default:   begin e.we = 5'b11111; e.flush = 2'b00; end
        endcase
        sbQ.push_back(e);

        // What the edge at the end of this cycle does
        if (r) begin
            mMode = 0; mRun = 0; mTout = 0;
            mStall = 0; mFlushN = 0; mMemN = 0;
        end else begin
            if (mMode == 1 && dh && mRun == HAZ_LIMIT) mTout = 1;
            if (act == "stall") begin
                mRun  = (mRun + 1 > HAZ_LIMIT) ? HAZ_LIMIT : mRun + 1;
                mMode = 1;
                if (mStall < PMAX) mStall++;
            end else begin
                mRun  = 0;
                mMode = (act == "freeze") ? 2 : 0;
            end
            if ((act == "branch" || act == "jump") && mFlushN < PMAX) mFlushN++;
            if (act == "freeze" && mMemN < PMAX) mMemN++;
        end
    endtask

    // Monitor: one response per cycle, compared field by field
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                chk("we_vector", {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we}, e.we, e.cyc);
                chk("flush_pair", {bus.if_id_flush, bus.id_ex_flush}, e.flush, e.cyc);
                chk("stall_state", bus.stall_state, e.state, e.cyc);
                chk("hazard_timeout", bus.hazard_timeout, e.tout, e.cyc);
                chk("perf_stall_cnt", bus.perf_stall_cnt, e.pStall, e.cyc);
                chk("perf_flush_cnt", bus.perf_flush_cnt, e.pFlush, e.cyc);
                chk("perf_memwait_cnt", bus.perf_memwait_cnt, e.pMem, e.cyc);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.data_hazard = 1'b0;
        bus.jump_id     = 1'b0;
        bus.branch_ex   = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_ready   = 1'b0;
        mMode = 0; mRun = 0; mTout = 0;
        mStall = 0; mFlushN = 0; mMemN = 0;

        // Reset for two cycles, then idle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Single hazard cycle: one bubble
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Memory wait of three not-ready cycles, then release
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
`ifdef PERF_CNT_EN
        chk("memwait_total_direct", bus.perf_memwait_cnt, 3, cycNo);
        chk("stall_total_direct", bus.perf_stall_cnt, 1, cycNo);
`endif

        // Branch beats hazard and jump
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Hazard held five cycles: watchdog trips and sticks
        repeat (5) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("timeout_set_direct", bus.hazard_timeout, 1, cycNo);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("timeout_sticky_direct", bus.hazard_timeout, 1, cycNo);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("timeout_cleared_direct", bus.hazard_timeout, 0, cycNo);

        // Branch seen while frozen is applied on release
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Reset in the middle of MEM_WAIT and of HAZ
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 79) == 0,
                $urandom_range(0, 99) < 40,
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 12,
                $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 50);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drain", 64'(sbQ.size()), 0, cycNo);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
